// File: rtl/sd_spi_cmd_if.sv
// Host-side command/response bundle for the SD SPI command engine.
// master = host control FSM, slave = sd_spi_cmd.
interface sd_spi_cmd_if;
  logic        start;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        resp_len;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  resp_r1;
  logic [31:0] resp_ext;

  modport master (
    output start, cmd_idx, cmd_arg, resp_len,
    input  busy, done, timeout, resp_r1, resp_ext
  );

  modport slave (
    input  start, cmd_idx, cmd_arg, resp_len,
    output busy, done, timeout, resp_r1, resp_ext
  );
endinterface

// File: rtl/sd_spi_cmd.sv
// SPI-mode SD command engine: sends a 6-byte command frame, polls for R1, optionally reads
// 4 trailing bytes. Define SD_CRC7_EN to compute CRC7 over the frame instead of the fixed 0x95.
module sd_spi_cmd #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           rst,
  sd_spi_cmd_if.slave    host,
  output logic           sclk,
  output logic           mosi,
  input  logic           miso,
  output logic           cs_n
);

  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntMax = (RESP_TIMEOUT > 6) ? RESP_TIMEOUT : 6;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StWait, StExt, StPost, StDone} state_e;

  state_e          state;
  logic [DivW-1:0] div_cnt;
  logic [2:0]      bit_cnt;
  logic [CntW-1:0] byte_cnt;
  logic [47:0]     tx_sr;
  logic [6:0]      rx_sr;
  logic            resp_len_q;
  logic            r1_hit;
  logic            busy_q;
  logic            done_q;
  logic            timeout_q;
  logic [7:0]      resp_r1_q;
  logic [31:0]     resp_ext_q;

  logic [39:0] head;
  logic [47:0] frame;
  logic [7:0]  rx_next;
  logic        half_end;

  assign head     = {2'b01, host.cmd_idx, host.cmd_arg};
  assign rx_next  = {rx_sr, miso};
  assign half_end = (div_cnt == DivW'(CLK_DIV - 1));

`ifdef SD_CRC7_EN
  logic [6:0] crc;

  always_comb begin
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      crc = (head[i] ^ crc[6]) ? ({crc[5:0], 1'b0} ^ 7'h09) : {crc[5:0], 1'b0};
    end
  end

  assign frame = {head, crc, 1'b1};
`else
  assign frame = {head, 8'h95};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      tx_sr      <= '1;
      rx_sr      <= '0;
      resp_len_q <= 1'b0;
      r1_hit     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      resp_r1_q  <= 8'hFF;
      resp_ext_q <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b1;
      cs_n       <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        StIdle: begin
          if (host.start) begin
            tx_sr      <= frame;
            mosi       <= frame[47];
            cs_n       <= 1'b0;
            busy_q     <= 1'b1;
            timeout_q  <= 1'b0;
            resp_r1_q  <= 8'hFF;
            resp_ext_q <= '0;
            resp_len_q <= host.resp_len;
            r1_hit     <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            sclk       <= 1'b0;
            state      <= StCmd;
          end
        end
        StDone: begin
          // One settle cycle after the last SCLK fall before reporting completion.
          if (bit_cnt == 3'd0) begin
            bit_cnt <= 3'd1;
          end else begin
            bit_cnt <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= StIdle;
          end
        end
        default: begin
          if (half_end) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
          end else begin
            div_cnt <= div_cnt + DivW'(1);
          end

          // Rising SCLK: sample MISO; R1 is decided on the bit0 sample.
          if (half_end && !sclk) begin
            rx_sr <= rx_next[6:0];
            if (state == StExt) begin
              resp_ext_q <= {resp_ext_q[30:0], miso};
            end
            if (state == StWait && bit_cnt == 3'd7 && !rx_next[7] && !r1_hit) begin
              resp_r1_q <= rx_next;
              r1_hit    <= 1'b1;
            end
          end

          // Falling SCLK: advance MOSI; tx_sr back-fills with ones so idle bytes send 0xFF.
          if (half_end && sclk) begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sr   <= {tx_sr[46:0], 1'b1};
            mosi    <= tx_sr[46];
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + CntW'(1);
              case (state)
                StCmd: begin
                  if (byte_cnt == CntW'(5)) begin
                    byte_cnt <= '0;
                    state    <= StWait;
                  end
                end
                StWait: begin
                  if (r1_hit) begin
                    byte_cnt <= '0;
                    if (resp_len_q) begin
                      state <= StExt;
                    end else begin
                      cs_n  <= 1'b1;
                      state <= StPost;
                    end
                  end else if (byte_cnt == CntW'(RESP_TIMEOUT - 1)) begin
                    byte_cnt  <= '0;
                    timeout_q <= 1'b1;
                    resp_r1_q <= 8'hFF;
                    cs_n      <= 1'b1;
                    state     <= StPost;
                  end
                end
                StExt: begin
                  if (byte_cnt == CntW'(3)) begin
                    byte_cnt <= '0;
                    cs_n     <= 1'b1;
                    state    <= StPost;
                  end
                end
                default: begin
                  byte_cnt <= '0;
                  state    <= StDone;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign host.busy     = busy_q;
  assign host.done     = done_q;
  assign host.timeout  = timeout_q;
  assign host.resp_r1  = resp_r1_q;
  assign host.resp_ext = resp_ext_q;

endmodule

// File: tb/tb_sd_spi_cmd.sv
// Directed bench for sd_spi_cmd: SD card model on the SPI pins, scoreboard of expected
// command results popped at each done pulse.
`timescale 1ns/1ps
module tb_sd_spi_cmd;
  localparam int unsigned CLK_DIV      = 2;
  localparam int unsigned RESP_TIMEOUT = 8;

  typedef struct {
    logic [47:0] frame;
    logic [7:0]  r1;
    logic        to;
    logic [31:0] ext;
    int          lat;
    int          bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sclk, mosi, miso, cs_n;

  sd_spi_cmd_if bus ();

  sd_spi_cmd #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .sclk (sclk),
    .mosi (mosi),
    .miso (miso),
    .cs_n (cs_n)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Card model: bit_pos counts SCLK rises while selected; cs_n falling starts a new frame.
  logic [7:0]  card_resp [24];
  int          bit_pos;
  int          post_rises;
  logic [47:0] cmd_seen;
  logic [7:0]  cur_byte;

  always @(posedge sclk or negedge cs_n) begin
    if (!sclk) begin
      bit_pos    <= 0;
      post_rises <= 0;
      cmd_seen   <= '0;
    end else if (!cs_n) begin
      if (bit_pos < 48) cmd_seen <= {cmd_seen[46:0], mosi};
      bit_pos <= bit_pos + 1;
    end else begin
      post_rises <= post_rises + 1;
    end
  end

  always_comb begin
    cur_byte = 8'hFF;
    if (bit_pos / 8 < 24) cur_byte = card_resp[5'(bit_pos / 8)];
    miso = cs_n ? 1'b1 : cur_byte[3'(7 - (bit_pos % 8))];
  end

  int   errors = 0;
  int   checks = 0;
  int   acc_cyc;
  exp_t sb [$];

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic rlen);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.cmd_idx  = idx;
    bus.cmd_arg  = arg;
    bus.resp_len = rlen;
    @(negedge clk);
    bus.start = 1'b0;
    acc_cyc   = cyc;
    check("accept_busy", bus.busy, 1);
    check("accept_cs_n", cs_n, 0);
    check("accept_mosi", mosi, 0);
  endtask

  // poll_n: poll byte (1-based) carrying R1; 0 means the card never answers.
  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic rlen,
                      input int poll_n, input logic [7:0] r1, input logic [31:0] ext);
    exp_t       e;
    logic       got;
    int         n, x;
    logic [7:0] c5;
    for (int i = 0; i < 24; i++) card_resp[i] = 8'hFF;
    if (poll_n >= 1 && poll_n <= 10) begin
      card_resp[5 + poll_n] = r1;
      if (rlen) begin
        for (int i = 0; i < 4; i++) card_resp[6 + poll_n + i] = ext[31 - 8*i -: 8];
      end
    end
`ifdef SD_CRC7_EN
    c5 = {crc7({2'b01, idx, arg}), 1'b1};
`else
    c5 = 8'h95;
`endif
    got     = (poll_n >= 1) && (poll_n <= RESP_TIMEOUT);
    n       = got ? poll_n : RESP_TIMEOUT;
    x       = (got && rlen) ? 1 : 0;
    e.frame = {2'b01, idx, arg, c5};
    e.r1    = got ? r1 : 8'hFF;
    e.to    = !got;
    e.ext   = x ? ext : 32'h0;
    e.lat   = (7 + n + 4*x) * 16 * CLK_DIV + 2;
    e.bits  = (6 + n + 4*x) * 8;
    sb.push_back(e);
    issue(idx, arg, rlen);
  endtask

  task automatic wait_done();
    exp_t e;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check("done_seen", bus.done, 1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      if (bus.done) begin
        check("latency", cyc - acc_cyc, e.lat);
        check("busy_at_done", bus.busy, 0);
        check("resp_r1", bus.resp_r1, e.r1);
        check("timeout", bus.timeout, e.to);
        check("resp_ext", bus.resp_ext, e.ext);
        check("mosi_frame", cmd_seen, e.frame);
        check("bits_selected", bit_pos, e.bits);
        check("post_sclk", post_rises, 8);
        check("cs_n_at_done", cs_n, 1);
        @(negedge clk);
        check("done_pulse_width", bus.done, 0);
        check("r1_held", bus.resp_r1, e.r1);
      end
    end
  endtask

  initial begin
    int n_done;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.cmd_idx  = '0;
    bus.cmd_arg  = '0;
    bus.resp_len = 1'b0;
    for (int i = 0; i < 24; i++) card_resp[i] = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_r1", bus.resp_r1, 8'hFF);
    check("rst_ext", bus.resp_ext, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 1);
    check("rst_cs_n", cs_n, 1);

    // CMD0, R1 on 2nd poll byte: 40 00 00 00 00 95, done 290 cycles after accept.
    send(6'd0, 32'h0, 1'b0, 2, 8'h01, 32'h0);
    wait_done();

    // CMD8 with R7 trailing bytes.
    send(6'd8, 32'h0000_01AA, 1'b1, 1, 8'h01, 32'h0000_01AA);
    wait_done();

    // Silent card: full poll budget, timeout, EXT skipped.
    send(6'd58, 32'h0, 1'b1, 0, 8'h00, 32'h0);
    wait_done();

    // R1 on the final allowed poll byte is a success.
    send(6'd41, 32'h4000_0000, 1'b0, 8, 8'h05, 32'h0);
    wait_done();

    // Second start while busy must not disturb the frame or queue a command.
    send(6'd17, 32'h1234_5678, 1'b0, 3, 8'h00, 32'h0);
    repeat (100) @(negedge clk);
    bus.start   = 1'b1;
    bus.cmd_idx = 6'd24;
    bus.cmd_arg = 32'hCAFE_F00D;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_during_restart", bus.busy, 1);
    wait_done();
    n_done = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("no_queued_cmd", n_done, 0);

    // Reset during command byte 3 aborts without done.
    for (int i = 0; i < 24; i++) card_resp[i] = 8'hFF;
    issue(6'd17, 32'h0, 1'b0);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bit_pos >= 26) break;
    end
    check("abort_in_byte3", (bit_pos >= 26) && (bit_pos < 32), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_mosi", mosi, 1);
    rst    = 1'b0;
    n_done = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Normal command after the abort.
    send(6'd0, 32'h0, 1'b1, 1, 8'h01, 32'hDEAD_BEEF);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
